// File: rtl/io_seg_display_pkg.sv
// Shared definitions for the I/O seven-segment display path: FSM states,
// segment constants (active-high) and the double-dabble nibble adjust.
package io_seg_display_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SHIFT = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Segment patterns are {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Largest value shown as two decimal digits; anything above shows "--".
  localparam int unsigned RANGE_MAX = 99;

  // Shift steps needed to convert the 7-bit value that survives the range check.
  localparam int unsigned SHIFT_CNT = 7;

  localparam int unsigned NUM_DIGITS = 6;

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/io_seg_display_if.sv
// Bundle between the memory-stage output ports and the display pins.
// The master drives the port values; the slave (the display) drives the digits.
interface io_seg_display_if;

  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;
  logic        disp_valid;

  modport master (
    output out_port0, out_port1, out_port2,
    input  hex0, hex1, hex2, hex3, hex4, hex5, disp_valid
  );

  modport slave (
    input  out_port0, out_port1, out_port2,
    output hex0, hex1, hex2, hex3, hex4, hex5, disp_valid
  );

endinterface

// File: rtl/io_seg_display_seg7_decoder.sv
// Combinational BCD/hex nibble to seven-segment decoder, active-high output.
// Dash wins over blank, blank wins over the nibble value.
module seg7_decoder
  import io_seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Select the pattern for the requested symbol.
  always_comb begin
    // NOTE: seg gets a default on entry so no path through this block leaves it
    // unassigned; without it a missing branch would infer a latch.
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      unique case (nibble)
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        4'hF: seg = 7'h71;
      endcase
    end
  end

endmodule

// File: rtl/io_seg_display.sv
// Round-robin display of three 32-bit I/O ports as two decimal digits each.
// One port is converted per 9-cycle slot: load (1), double-dabble shift (7),
// write (1). Digits are registered, so the pins never see the ports directly.
module io_seg_display
  import io_seg_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEAD0    = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  io_seg_display_if.slave   bus
);

  // Pattern with every segment dark in the board's polarity.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t      state_q;
  logic [1:0]  idx_q;       // port currently being converted (0..2)
  logic [6:0]  work_q;      // low bits of the snapshot; upper bits only feed range_q
  logic [7:0]  bcd_q;       // {tens, ones}
  logic [2:0]  cnt_q;
  logic        range_q;     // snapshot exceeded RANGE_MAX (includes bit31 set)
  logic [6:0]  hex_q [NUM_DIGITS];
  logic        valid_q;

  logic [31:0] sel_port;
  logic [7:0]  bcd_adj;
  logic        tens_blank;
  logic [6:0]  tens_seg;
  logic [6:0]  ones_seg;
  logic [6:0]  tens_pin;
  logic [6:0]  ones_pin;
  logic [2:0]  ones_slot;
  logic [2:0]  tens_slot;

  // Port selected by the round-robin index.
  always_comb begin
    sel_port = bus.out_port0;
    unique case (idx_q)
      2'd1:    sel_port = bus.out_port1;
      2'd2:    sel_port = bus.out_port2;
      default: sel_port = bus.out_port0;
    endcase
  end

  // Add-3 correction of both BCD nibbles ahead of the next shift.
  always_comb begin
    bcd_adj = {bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};
  end

  assign tens_blank = BLANK_LEAD0 && (bcd_q[7:4] == 4'd0);

  seg7_decoder u_tens (
    .nibble (bcd_q[7:4]),
    .blank  (tens_blank),
    .dash   (range_q),
    .seg    (tens_seg)
  );

  seg7_decoder u_ones (
    .nibble (bcd_q[3:0]),
    .blank  (1'b0),
    .dash   (range_q),
    .seg    (ones_seg)
  );

  assign tens_pin  = SEG_ACTIVE_LOW ? ~tens_seg : tens_seg;
  assign ones_pin  = SEG_ACTIVE_LOW ? ~ones_seg : ones_seg;
  assign ones_slot = {idx_q, 1'b0};
  assign tens_slot = {idx_q, 1'b1};

  // Conversion FSM with the registered digit bank and sticky valid flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_LOAD;
      idx_q   <= 2'd0;
      work_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      range_q <= 1'b0;
      valid_q <= 1'b0;
      // NOTE: the digit bank is six small pin registers, not a RAM, so it is
      // reset explicitly; the pins must go dark the moment resetn drops.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_q[i] <= SEG_OFF;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // below reads the value from before this edge regardless of order.
      unique case (state_q)
        S_LOAD: begin
          work_q  <= sel_port[6:0];
          bcd_q   <= '0;
          range_q <= (sel_port > 32'(RANGE_MAX));
          cnt_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd_q  <= {bcd_adj[6:0], work_q[6]};
          work_q <= {work_q[5:0], 1'b0};
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'(SHIFT_CNT - 1)) begin
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          hex_q[ones_slot] <= ones_pin;
          hex_q[tens_slot] <= tens_pin;
          if (idx_q == 2'd2) begin
            valid_q <= 1'b1;
            idx_q   <= 2'd0;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
          state_q <= S_LOAD;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus.hex0       = hex_q[0];
  assign bus.hex1       = hex_q[1];
  assign bus.hex2       = hex_q[2];
  assign bus.hex3       = hex_q[3];
  assign bus.hex4       = hex_q[4];
  assign bus.hex5       = hex_q[5];
  assign bus.disp_valid = valid_q;

endmodule
